// File: rtl/led_afterglow.sv
// led_afterglow: per-LED fading driver placed after the cylon sweep generator.
// Each lit sweep LED leaves a PWM afterglow trail that decays one level per
// decay tick. A static status pattern and an error-blink override are muxed
// in ahead of the registered LED drive.
//
// Build option: define LED_AFTERGLOW_EN to build the level/PWM/decay path.
// Without it the sweep is passed straight through (pattern_r -> led_out),
// while the prescaler, blink logic and output priority stay the same.
module led_afterglow #(
  parameter int NLED      = 12,
  parameter int PWMBITS   = 4,
  parameter int DECAY_PRE = 18
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NLED-1:0] pattern_in,
  input  logic [NLED-1:0] status_in,
  input  logic            sel_status,
  input  logic            blink_err,
  output logic [NLED-1:0] led_out
);

  localparam logic [DECAY_PRE-1:0] PRE_ZERO   = {DECAY_PRE{1'b0}};
  localparam logic [DECAY_PRE-1:0] PRE_ONE    = {{(DECAY_PRE-1){1'b0}}, 1'b1};
  localparam logic [2:0]           BLINK_ONE  = 3'd1;
  localparam logic [2:0]           BLINK_LAST = 3'd7;
  localparam logic [NLED-1:0]      LED_ZERO   = {NLED{1'b0}};

  // Registered copies of every input.
  logic [NLED-1:0] pattern_r;
  logic [NLED-1:0] status_r;
  logic            sel_r;
  logic            blink_r;

  // Shared timebase.
  logic [DECAY_PRE-1:0] pre_cnt;
  logic                 decay_tick;
  logic [2:0]           blink_cnt;
  logic                 blink_phase;

  // Sweep-path result feeding the output mux.
  logic [NLED-1:0] sweep;

  // Output priority: blink override first, then the status pattern, then the sweep.
  function automatic logic [NLED-1:0] select_out(
    input logic            blink_sel,
    input logic            phase,
    input logic            status_sel,
    input logic [NLED-1:0] status_bits,
    input logic [NLED-1:0] sweep_bits
  );
    logic [NLED-1:0] result;
    if (blink_sel) begin
      result = {NLED{phase}};
    end else if (status_sel) begin
      result = status_bits;
    end else begin
      result = sweep_bits;
    end
    return result;
  endfunction

  // Input stage: capture all control and pattern inputs once per clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pattern_r <= LED_ZERO;
      status_r  <= LED_ZERO;
      sel_r     <= 1'b0;
      blink_r   <= 1'b0;
    end else begin
      pattern_r <= pattern_in;
      status_r  <= status_in;
      sel_r     <= sel_status;
      blink_r   <= blink_err;
    end
  end

  // Free-running prescaler; the all-ones state marks one decay tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= PRE_ZERO;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  assign decay_tick = &pre_cnt;

  // Blink divider: counts decay ticks and flips the blink phase every eighth one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= 3'd0;
      blink_phase <= 1'b0;
    end else if (decay_tick) begin
      blink_cnt <= blink_cnt + BLINK_ONE;
      if (blink_cnt == BLINK_LAST) begin
        blink_phase <= ~blink_phase;
      end else begin
        blink_phase <= blink_phase;
      end
    end else begin
      blink_cnt   <= blink_cnt;
      blink_phase <= blink_phase;
    end
  end

`ifdef LED_AFTERGLOW_EN

  localparam logic [PWMBITS-1:0] LVL_MAX  = {PWMBITS{1'b1}};
  localparam logic [PWMBITS-1:0] LVL_ZERO = {PWMBITS{1'b0}};
  localparam logic [PWMBITS-1:0] LVL_ONE  = {{(PWMBITS-1){1'b0}}, 1'b1};

  logic [PWMBITS-1:0] pwm_cnt;
  logic [PWMBITS-1:0] lvl [NLED];
  logic               sel_d;

  // A channel is lit at full level, or while its level exceeds the PWM ramp,
  // so level L yields an L/2^PWMBITS duty and level 0 never lights.
  function automatic logic chan_on(
    input logic [PWMBITS-1:0] level,
    input logic [PWMBITS-1:0] pwm
  );
    return (level == LVL_MAX) || (level > pwm);
  endfunction

  // PWM ramp shared by all channels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= LVL_ZERO;
    end else begin
      pwm_cnt <= pwm_cnt + LVL_ONE;
    end
  end

  // Delayed select, used to spot the cycle where status mode is left.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_d <= 1'b0;
    end else begin
      sel_d <= sel_r;
    end
  end

  // Per-channel level: status mode clears, a lit sweep bit loads MAX (beating
  // both the exit clear and a coincident tick), otherwise decay to zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NLED; i++) begin
        lvl[i] <= LVL_ZERO;
      end
    end else begin
      for (int i = 0; i < NLED; i++) begin
        if (sel_r) begin
          lvl[i] <= LVL_ZERO;
        end else if (pattern_r[i]) begin
          lvl[i] <= LVL_MAX;
        end else if (sel_d) begin
          lvl[i] <= LVL_ZERO;
        end else if (decay_tick && (lvl[i] != LVL_ZERO)) begin
          lvl[i] <= lvl[i] - LVL_ONE;
        end else begin
          lvl[i] <= lvl[i];
        end
      end
    end
  end

  // Sweep path renders every channel's level through the PWM comparator.
  always_comb begin
    sweep = LED_ZERO;
    for (int i = 0; i < NLED; i++) begin
      sweep[i] = chan_on(lvl[i], pwm_cnt);
    end
  end

`else

  // Sweep path without afterglow: the registered pattern goes straight out.
  always_comb begin
    sweep = pattern_r;
  end

`endif

  // Registered LED drive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= LED_ZERO;
    end else begin
      led_out <= select_out(blink_r, blink_phase, sel_r, status_r, sweep);
    end
  end

endmodule

// File: tb/tb_led_afterglow.sv
// Self-checking bench for led_afterglow (DECAY_PRE=3, PWMBITS=4). The
// reference model derives the prescaler, PWM ramp and blink phase from the
// number of clock edges since reset and keeps channel levels as integers.
// Works with or without LED_AFTERGLOW_EN.
module tb_led_afterglow;

  localparam int NLED      = 12;
  localparam int PWMBITS   = 4;
  localparam int DECAY_PRE = 3;
  localparam int MAXL      = (1 << PWMBITS) - 1;
  localparam int PWMP      = 1 << PWMBITS;
  localparam int TICKP     = 1 << DECAY_PRE;
  localparam int BLINKP    = 8 * TICKP;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  logic [NLED-1:0] pattern_in = '0;
  logic [NLED-1:0] status_in = '0;
  logic            sel_status = 1'b0;
  logic            blink_err = 1'b0;
  logic [NLED-1:0] led_out;

  int checks = 0;
  int errors = 0;

  led_afterglow #(
    .NLED(NLED),
    .PWMBITS(PWMBITS),
    .DECAY_PRE(DECAY_PRE)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pattern_in(pattern_in),
    .status_in(status_in),
    .sel_status(sel_status),
    .blink_err(blink_err),
    .led_out(led_out)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int              n = 0;          // clock edges since reset release
  logic [NLED-1:0] m_pat = '0;
  logic [NLED-1:0] m_stat = '0;
  logic            m_sel = 1'b0;
  logic            m_sel_prev = 1'b0;
  logic            m_blink = 1'b0;
  logic [NLED-1:0] m_led = '0;
  int              m_lvl [NLED];

  function automatic logic [NLED-1:0] model_led();
    logic [NLED-1:0] v;
    int   pwm;
    logic phase;
    pwm   = n % PWMP;
    phase = ((n / BLINKP) % 2) == 1;
    v     = '0;
    if (m_blink) v = {NLED{phase}};
    else if (m_sel) v = m_stat;
    else begin
`ifdef LED_AFTERGLOW_EN
      for (int i = 0; i < NLED; i++) v[i] = (m_lvl[i] == MAXL) || (m_lvl[i] > pwm);
`else
      v = m_pat;
`endif
    end
    return v;
  endfunction

  function automatic int model_next_lvl(input int i);
    logic tick;
    tick = (n % TICKP) == (TICKP - 1);
    if (m_sel) return 0;
    if (m_pat[i]) return MAXL;
    if (m_sel_prev) return 0;
    if (tick && m_lvl[i] > 0) return m_lvl[i] - 1;
    return m_lvl[i];
  endfunction

  // Model state advances on each clock edge; reset clears everything at once.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n <= 0;
      m_pat <= '0; m_stat <= '0; m_sel <= 1'b0; m_sel_prev <= 1'b0; m_blink <= 1'b0;
      m_led <= '0;
      for (int i = 0; i < NLED; i++) m_lvl[i] <= 0;
    end else begin
      m_led <= model_led();
      for (int i = 0; i < NLED; i++) m_lvl[i] <= model_next_lvl(i);
      m_pat <= pattern_in; m_stat <= status_in; m_sel <= sel_status;
      m_sel_prev <= m_sel; m_blink <= blink_err;
      n <= n + 1;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    pattern_in = 12'hFFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (led_out !== 12'h000) begin
        errors++; $display("FAIL reset_hold k=%0d: led_out=%h expected=000", k, led_out);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      checks++;
      if (led_out !== m_led) begin
        errors++; $display("FAIL reset_release_model k=%0d: led_out=%h expected=%h", k, led_out, m_led);
      end
    end
    checks++;
    if (led_out !== 12'hFFF) begin
      errors++; $display("FAIL reset_release_edge3: led_out=%h expected=fff", led_out);
    end
  endtask

  task automatic test_trail();
    int on0 = 0, off0 = 0, bit1_off = 0, tail_on = 0;
    pattern_in = 12'h001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++;
      if (led_out !== m_led) begin
        errors++; $display("FAIL trail_set_model: led_out=%h expected=%h", led_out, m_led);
      end
    end
    pattern_in = 12'h002;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clock);
      checks++;
      if (led_out !== m_led) begin
        errors++; $display("FAIL trail_model k=%0d: led_out=%h expected=%h", k, led_out, m_led);
      end
      if (k >= 3 && !led_out[1]) bit1_off++;
      if (k >= 4 && k <= 100) begin
        if (led_out[0]) on0++; else off0++;
      end
      if (k > 140 && led_out[0]) tail_on++;
    end
    checks++;
    if (bit1_off !== 0) begin
      errors++; $display("FAIL trail_bit1_steady: off_samples=%0d expected=0", bit1_off);
    end
    checks++;
    if (tail_on !== 0) begin
      errors++; $display("FAIL trail_end_dark: on_samples=%0d expected=0", tail_on);
    end
`ifdef LED_AFTERGLOW_EN
    checks++;
    if (on0 == 0 || off0 == 0) begin
      errors++; $display("FAIL trail_pwm: on=%0d off=%0d expected both nonzero", on0, off0);
    end
`else
    checks++;
    if (on0 !== 0) begin
      errors++; $display("FAIL trail_none: on=%0d expected=0", on0);
    end
`endif
  endtask

  task automatic test_tick_collision();
    int guard = 0;
    int on_cnt = 0;
    pattern_in = 12'h000;
    repeat (20) @(negedge clock);
    while ((n % PWMP) != (PWMP - 2) && guard < 64) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if ((n % PWMP) != (PWMP - 2)) begin
      errors++; $display("FAIL collide_align: phase=%0d expected=%0d", n % PWMP, PWMP - 2);
    end
    pattern_in = 12'h001;
    @(negedge clock);
    pattern_in = 12'h000;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      checks++;
      if (led_out !== m_led) begin
        errors++; $display("FAIL collide_model k=%0d: led_out=%h expected=%h", k, led_out, m_led);
      end
      if (k >= 2 && k <= 9 && led_out[0]) on_cnt++;
    end
`ifdef LED_AFTERGLOW_EN
    checks++;
    if (on_cnt !== 8) begin
      errors++; $display("FAIL collide_full_level: on_samples=%0d expected=8", on_cnt);
    end
`endif
  endtask

  task automatic test_status();
    sel_status = 1'b1;
    status_in  = 12'hA5A;
    pattern_in = 12'($urandom);
    @(negedge clock);
    pattern_in = 12'($urandom);
    @(negedge clock);
    checks++;
    if (led_out !== 12'hA5A) begin
      errors++; $display("FAIL status_show: led_out=%h expected=a5a", led_out);
    end
    for (int k = 0; k < 10; k++) begin
      pattern_in = 12'($urandom);
      @(negedge clock);
      checks++;
      if (led_out !== m_led) begin
        errors++; $display("FAIL status_model: led_out=%h expected=%h", led_out, m_led);
      end
    end
    sel_status = 1'b0;
    pattern_in = 12'h000;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k >= 2) begin
        checks++;
        if (led_out !== 12'h000) begin
          errors++; $display("FAIL status_exit_dark k=%0d: led_out=%h expected=000", k, led_out);
        end
      end
    end
  endtask

  task automatic test_blink();
    int   toggles = 0;
    int   last_t = -1;
    logic [NLED-1:0] prev;
    sel_status = 1'b1;
    status_in  = 12'hA5A;
    blink_err  = 1'b1;
    @(negedge clock);
    @(negedge clock);
    prev = led_out;
    for (int k = 0; k < 220; k++) begin
      @(negedge clock);
      checks++;
      if (led_out !== m_led) begin
        errors++; $display("FAIL blink_model k=%0d: led_out=%h expected=%h", k, led_out, m_led);
      end
      checks++;
      if (led_out !== 12'h000 && led_out !== 12'hFFF) begin
        errors++; $display("FAIL blink_uniform k=%0d: led_out=%h expected=000/fff", k, led_out);
      end
      if (led_out !== prev) begin
        if (last_t >= 0) begin
          checks++;
          if (k - last_t != BLINKP) begin
            errors++; $display("FAIL blink_period: got=%0d expected=%0d", k - last_t, BLINKP);
          end
        end
        last_t = k;
        toggles++;
      end
      prev = led_out;
    end
    checks++;
    if (toggles < 2) begin
      errors++; $display("FAIL blink_toggles: got=%0d expected>=2", toggles);
    end
    blink_err  = 1'b0;
    sel_status = 1'b0;
    pattern_in = 12'h000;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      int r = $urandom_range(0, 99);
      if (r < 60) pattern_in = 12'h001 << $urandom_range(0, 11);
      else if (r < 80) pattern_in = 12'h000;
      else pattern_in = 12'($urandom);
      status_in = 12'($urandom);
      if ($urandom_range(0, 29) == 0) sel_status = ~sel_status;
      if (blink_err) begin
        if ($urandom_range(0, 9) == 0) blink_err = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        blink_err = 1'b1;
      end
      @(negedge clock);
      checks++;
      if (led_out !== m_led) begin
        errors++; $display("FAIL random_model k=%0d: led_out=%h expected=%h", k, led_out, m_led);
      end
    end
    blink_err = 1'b0;
    sel_status = 1'b0;
    pattern_in = 12'h000;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_trail();
    pattern_in = 12'hFFF;
    repeat (5) @(negedge clock);
    pattern_in = 12'h000;
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 12'h000) begin
      errors++; $display("FAIL midreset_immediate: led_out=%h expected=000", led_out);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      checks++;
      if (led_out !== 12'h000) begin
        errors++; $display("FAIL midreset_no_trail k=%0d: led_out=%h expected=000", k, led_out);
      end
    end
  endtask

`ifndef LED_AFTERGLOW_EN
  task automatic test_pulse();
    logic [NLED-1:0] exp_v;
    pattern_in = 12'h000;
    repeat (4) @(negedge clock);
    pattern_in = 12'h010;
    @(negedge clock);
    pattern_in = 12'h000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      exp_v = (k == 1) ? 12'h010 : 12'h000;
      checks++;
      if (led_out !== exp_v) begin
        errors++; $display("FAIL pulse k=%0d: led_out=%h expected=%h", k, led_out, exp_v);
      end
    end
  endtask
`endif

  initial begin
    #2 reset_n = 1'b0;
    test_reset();
    test_trail();
    test_tick_collision();
    test_status();
    test_blink();
    test_random();
    test_reset_mid_trail();
`ifndef LED_AFTERGLOW_EN
    test_pulse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
